stopwatch_ctrl: RTL and testbench

Control FSM that sequences the stopwatch counter datapath. It synchronizes and debounces the raw push-buttons and converts them into single-cycle command pulses. It drives the counter's reset and pause inputs plus the adjust-mode signals used to set minutes and seconds. It sits between the board I/O and the counter/display path, in the same clock domain as the counter.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/btn_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_t         : 2-bit FSM state type
//   ST_RUN/ST_PAUSE/ST_ADJUST : state encodings (2'b11 is illegal)
//   DEB_CYCLES_DEF  : default debounce length in clock cycles
package stopwatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'b00;
    localparam state_t ST_PAUSE  = 2'b01;
    localparam state_t ST_ADJUST = 2'b10;

    localparam int unsigned DEB_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge press detector for one raw button.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous, bouncy button level
//   press   : registered one-cycle pulse on each rising edge of the debounced level
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DEB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [DEB_W-1:0] cnt_q;
    logic             differ;
    logic             flip;

    assign differ = (sync2_q != level_q);
    // Flip only after DEB_CYCLES consecutive cycles of disagreement.
    assign flip   = differ && (cnt_q == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            if (!differ || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                level_q <= ~level_q;
            end
            press_q <= flip && !level_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced buttons and the adjust switches into counter
// controls (clear pulse, hold, adjust mode, increment pulses, blink).
// Optional feature macro: STOPWATCH_LAP_EN adds btn_lap / freeze (lap display hold).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   btn_pause, btn_reset : raw bouncy buttons
//   sw_adj, sw_sel       : raw switch levels (synchronized, not debounced)
//   tick_fast            : ~2 Hz single-cycle pulse, clk-synchronous
//   btn_lap, freeze      : lap button / display freeze (STOPWATCH_LAP_EN only)
//   cnt_rst              : one-cycle counter clear
//   paused               : counter hold (PAUSE and ADJUST)
//   adj_en, adj_sel      : adjust mode and field select (0 = seconds, 1 = minutes)
//   adj_inc              : one-cycle increment for the selected field
//   blank                : blink phase for the selected digits
//   state                : current FSM state
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned DEB_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       tick_fast,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
    output logic       freeze,
`endif
    output logic       cnt_rst,
    output logic       paused,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       adj_inc,
    output logic       blank,
    output logic [1:0] state
);

    logic   pause_press;
    logic   reset_press;
    logic   adj_s1_q, adj_s2_q;
    logic   sel_s1_q, sel_s2_q;
    state_t state_q, state_d;
    logic   cnt_rst_q, cnt_rst_d;
    logic   paused_q, adj_en_q, adj_sel_q, adj_inc_q, blank_q;
    logic   stay_adj;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_pause (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_pause),
        .press   (pause_press)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_reset (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_reset),
        .press   (reset_press)
    );

    always_comb begin
        state_d   = state_q;
        cnt_rst_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (reset_press) begin
                    state_d   = ST_PAUSE;
                    cnt_rst_d = 1'b1;
                end else if (adj_s2_q) begin
                    state_d = ST_ADJUST;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (reset_press) begin
                    cnt_rst_d = 1'b1;
                end else if (adj_s2_q) begin
                    state_d = ST_ADJUST;
                end else if (pause_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                // Pause presses are dropped here, not remembered for later.
                if (reset_press) begin
                    cnt_rst_d = 1'b1;
                end else if (!adj_s2_q) begin
                    state_d = ST_PAUSE;
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    // Ticks count only when ADJUST holds across the edge (not on entry or exit).
    assign stay_adj = (state_q == ST_ADJUST) && (state_d == ST_ADJUST);

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_s1_q  <= 1'b0;
            adj_s2_q  <= 1'b0;
            sel_s1_q  <= 1'b0;
            sel_s2_q  <= 1'b0;
            state_q   <= ST_PAUSE;
            cnt_rst_q <= 1'b0;
            paused_q  <= 1'b1;
            adj_en_q  <= 1'b0;
            adj_sel_q <= 1'b0;
            adj_inc_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            adj_s1_q  <= sw_adj;
            adj_s2_q  <= adj_s1_q;
            sel_s1_q  <= sw_sel;
            sel_s2_q  <= sel_s1_q;
            state_q   <= state_d;
            cnt_rst_q <= cnt_rst_d;
            paused_q  <= (state_d != ST_RUN);
            adj_en_q  <= (state_d == ST_ADJUST);
            adj_sel_q <= (state_d == ST_ADJUST) && sel_s2_q;
            adj_inc_q <= stay_adj && tick_fast;
            if (state_d != ST_ADJUST) begin
                blank_q <= 1'b0;
            end else if (stay_adj && tick_fast) begin
                blank_q <= ~blank_q;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_press;
    logic freeze_q;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_lap (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_lap),
        .press   (lap_press)
    );

    // Any exit from RUN (including a clear) drops the freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_q <= 1'b0;
        end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            freeze_q <= freeze_q ^ lap_press;
        end else begin
            freeze_q <= 1'b0;
        end
    end

    assign freeze = freeze_q;
`endif

    assign cnt_rst = cnt_rst_q;
    assign paused  = paused_q;
    assign adj_en  = adj_en_q;
    assign adj_sel = adj_sel_q;
    assign adj_inc = adj_inc_q;
    assign blank   = blank_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic       tick_fast = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap = 1'b0;
    logic       freeze;
`endif
    logic       cnt_rst, paused, adj_en, adj_sel, adj_inc, blank;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DEB_CYCLES (4),
        .DEB_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_reset (btn_reset),
        .sw_adj    (sw_adj),
        .sw_sel    (sw_sel),
        .tick_fast (tick_fast),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
        .freeze    (freeze),
`endif
        .cnt_rst   (cnt_rst),
        .paused    (paused),
        .adj_en    (adj_en),
        .adj_sel   (adj_sel),
        .adj_inc   (adj_inc),
        .blank     (blank),
        .state     (state)
    );

    // Output vector: {cnt_rst, paused, adj_en, adj_sel, adj_inc, blank, state}
    function automatic logic [7:0] ov(input logic [1:0] st, input logic cr, input logic ps,
                                      input logic ae, input logic as, input logic ai,
                                      input logic bl);
        return {cr, ps, ae, as, ai, bl, st};
    endfunction

    function automatic logic [7:0] obs();
        return {cnt_rst, paused, adj_en, adj_sel, adj_inc, blank, state};
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [7:0] o);
        sb_t e;
        e = sb_q.pop_front();
        checks++;
        assert (o === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
        end
    endtask

    // Push an expectation, wait n edges, then compare against the DUT outputs.
    task automatic expect_after(input string tag, input int n, input logic [7:0] exp);
        push(tag, exp);
        step(n);
        pop_check(obs());
    endtask

    task automatic count_check(input string tag, input int o, input int exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, exp);
        end
    endtask

    initial begin
        int n_rst;
        int n_bad;

        // 1. reset
        step(2);
        rst = 1'b0;
        push("reset", ov(2'b01, 0, 1, 0, 0, 0, 0));
        pop_check(obs());

        // 2. pause press, raw change after edge E -> state changes at E+7
        btn_pause = 1'b1;
        expect_after("pause_e6", 6, ov(2'b01, 0, 1, 0, 0, 0, 0));
        expect_after("pause_e7", 1, ov(2'b00, 0, 0, 0, 0, 0, 0));
        step(3);
        btn_pause = 1'b0;
        expect_after("pause_release", 12, ov(2'b00, 0, 0, 0, 0, 0, 0));

        // 2b. 3-cycle glitch is rejected
        btn_pause = 1'b1;
        step(3);
        btn_pause = 1'b0;
        expect_after("glitch", 12, ov(2'b00, 0, 0, 0, 0, 0, 0));

        // 3. reset press in RUN, then hold
        btn_reset = 1'b1;
        expect_after("rst_e6", 6, ov(2'b00, 0, 0, 0, 0, 0, 0));
        expect_after("rst_e7", 1, ov(2'b01, 1, 1, 0, 0, 0, 0));
        expect_after("rst_e8", 1, ov(2'b01, 0, 1, 0, 0, 0, 0));
        n_rst = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (cnt_rst) n_rst++;
        end
        count_check("rst_hold_pulses", n_rst, 0);
        btn_reset = 1'b0;
        step(10);

        // 4. adjust mode
        sw_adj = 1'b1;
        expect_after("adj_e2", 2, ov(2'b01, 0, 1, 0, 0, 0, 0));
        expect_after("adj_e3", 1, ov(2'b10, 0, 1, 1, 0, 0, 0));
        for (int t = 0; t < 3; t++) begin
            logic b;
            b = (t % 2 == 0);
            tick_fast = 1'b1;
            push("tick_inc", ov(2'b10, 0, 1, 1, 0, 1, b));
            step(1);
            tick_fast = 1'b0;
            pop_check(obs());
            expect_after("tick_hold", 2, ov(2'b10, 0, 1, 1, 0, 0, b));
        end
        sw_sel = 1'b1;
        expect_after("sel_e2", 2, ov(2'b10, 0, 1, 1, 0, 0, 1));
        expect_after("sel_e3", 1, ov(2'b10, 0, 1, 1, 1, 0, 1));
        sw_adj = 1'b0;
        expect_after("adj_exit_e2", 2, ov(2'b10, 0, 1, 1, 1, 0, 1));
        expect_after("adj_exit_e3", 1, ov(2'b01, 0, 1, 0, 0, 0, 0));
        sw_sel = 1'b0;
        step(3);

        // 5. simultaneous pause + reset in RUN
        btn_pause = 1'b1;
        step(10);
        btn_pause = 1'b0;
        expect_after("to_run", 10, ov(2'b00, 0, 0, 0, 0, 0, 0));
        btn_pause = 1'b1;
        btn_reset = 1'b1;
        expect_after("both_e7", 7, ov(2'b01, 1, 1, 0, 0, 0, 0));
        n_rst = 0;
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cnt_rst) n_rst++;
            if (state == 2'b00) n_bad++;
        end
        count_check("both_extra_rst", n_rst, 0);
        count_check("both_run_seen", n_bad, 0);
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        expect_after("both_release", 12, ov(2'b01, 0, 1, 0, 0, 0, 0));

        // 6a. rst mid-ADJUST
        sw_adj = 1'b1;
        expect_after("adj2_enter", 3, ov(2'b10, 0, 1, 1, 0, 0, 0));
        rst = 1'b1;
        sw_adj = 1'b0;
        expect_after("rst_mid_adj", 1, ov(2'b01, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        expect_after("after_rst_adj", 5, ov(2'b01, 0, 1, 0, 0, 0, 0));

        // 6b. rst mid-debounce: partial press must not complete
        btn_pause = 1'b1;
        step(4);
        rst = 1'b1;
        expect_after("rst_mid_deb", 1, ov(2'b01, 0, 1, 0, 0, 0, 0));
        btn_pause = 1'b0;
        rst = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (state != 2'b01) n_bad++;
        end
        count_check("partial_press", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
